// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter: up to four AXI4-Stream sources share one
// AXI4-Stream master port. A granted source owns the output until its tlast beat
// is accepted, after which a fixed inter-frame gap is inserted before the next grant.
module axis_rr_pkt_arbiter #(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_NUM_PORTS       = 4,
    parameter int C_IFG_CYCLES      = 5
) (
    input  logic                                   axi_aclk,
    input  logic                                   axi_reset,
    input  logic                                   enable,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_PORTS-1:0]                 s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                 s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                 s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]         m_axis_tstrb,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic [1:0]                             grant_id,
    output logic                                   busy,
    output logic [31:0]                            pkt_count
);

    localparam int         LP_STRB_W    = C_AXIS_DATA_WIDTH / 8;
    localparam logic [7:0] LP_IFG       = 8'(C_IFG_CYCLES);
    localparam logic [1:0] LP_LAST_PORT = 2'(C_NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [7:0]  r_gap_cnt;
    logic [31:0] r_pkt_count;

    logic        w_req_found;
    logic [1:0]  w_next_grant;
    logic        w_accept_last;

    // Round-robin search: first requesting port after the last granted one.
    always_comb begin
        int v_idx;
        v_idx        = 0;
        w_req_found  = 1'b0;
        w_next_grant = r_grant;
        for (int k = 1; k <= C_NUM_PORTS; k++) begin
            v_idx = (int'(r_grant) + k) % C_NUM_PORTS;
            for (int p = 0; p < C_NUM_PORTS; p++) begin
                if (!w_req_found && (p == v_idx) && s_axis_tvalid[p]) begin
                    w_req_found  = 1'b1;
                    w_next_grant = 2'(p);
                end else begin
                    w_req_found  = w_req_found;
                end
            end
        end
    end

    // Output mux: the granted slice passes straight through while in XFER, else all zero.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == ST_XFER) begin
            for (int p = 0; p < C_NUM_PORTS; p++) begin
                if (r_grant == 2'(p)) begin
                    m_axis_tdata     = s_axis_tdata[p*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                    m_axis_tstrb     = s_axis_tstrb[p*LP_STRB_W +: LP_STRB_W];
                    m_axis_tvalid    = s_axis_tvalid[p];
                    m_axis_tlast     = s_axis_tlast[p];
                    s_axis_tready[p] = m_axis_tready;
                end else begin
                    s_axis_tready[p] = 1'b0;
                end
            end
        end else begin
            m_axis_tvalid = 1'b0;
        end
    end

    assign w_accept_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Arbitration FSM: grant on packet boundaries, count packets, time the gap.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= LP_LAST_PORT;
            r_gap_cnt   <= 8'd0;
            r_pkt_count <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_req_found) begin
                        r_grant <= w_next_grant;
                        r_state <= ST_XFER;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (w_accept_last) begin
                        r_pkt_count <= r_pkt_count + 32'd1;
                        r_gap_cnt   <= LP_IFG;
                        r_state     <= (LP_IFG != 8'd0) ? ST_GAP : ST_IDLE;
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                    // A count of 0 cannot normally occur here; treat it like 1 to avoid a stuck gap.
                    if (r_gap_cnt <= 8'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state == ST_XFER);
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed bench for axis_rr_pkt_arbiter: behavioural packet sources feed two
// instances (gap 5 and gap 0); expected values are hand-derived per cycle.
module tb_axis_rr_pkt_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int SW = W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic m_tready = 1'b1;
    logic sel_b = 1'b0;

    logic [N*W-1:0]  s_tdata;
    logic [N*SW-1:0] s_tstrb;
    logic [N-1:0]    s_tvalid, s_tlast, tready_a, tready_b, src_tready;

    logic [W-1:0]  tdata_a, tdata_b, o_tdata;
    logic [SW-1:0] tstrb_a, tstrb_b, o_tstrb;
    logic          tvalid_a, tvalid_b, o_tvalid;
    logic          tlast_a, tlast_b, o_tlast;
    logic [1:0]    grant_a, grant_b, o_grant;
    logic          busy_a, busy_b, o_busy;
    logic [31:0]   pkt_a, pkt_b, o_pkt;
    logic [N-1:0]  o_tready;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    axis_rr_pkt_arbiter #(.C_AXIS_DATA_WIDTH(W), .C_NUM_PORTS(N), .C_IFG_CYCLES(5)) dut_a (
        .axi_aclk(clk), .axi_reset(rst), .enable(enable),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(tready_a),
        .m_axis_tdata(tdata_a), .m_axis_tstrb(tstrb_a), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(m_tready), .m_axis_tlast(tlast_a),
        .grant_id(grant_a), .busy(busy_a), .pkt_count(pkt_a));

    axis_rr_pkt_arbiter #(.C_AXIS_DATA_WIDTH(W), .C_NUM_PORTS(N), .C_IFG_CYCLES(0)) dut_b (
        .axi_aclk(clk), .axi_reset(rst), .enable(enable),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(tready_b),
        .m_axis_tdata(tdata_b), .m_axis_tstrb(tstrb_b), .m_axis_tvalid(tvalid_b),
        .m_axis_tready(m_tready), .m_axis_tlast(tlast_b),
        .grant_id(grant_b), .busy(busy_b), .pkt_count(pkt_b));

    // Observed instance selected by sel_b; sources follow its tready.
    always_comb begin
        src_tready = sel_b ? tready_b : tready_a;
        o_tready   = sel_b ? tready_b : tready_a;
        o_tdata    = sel_b ? tdata_b  : tdata_a;
        o_tstrb    = sel_b ? tstrb_b  : tstrb_a;
        o_tvalid   = sel_b ? tvalid_b : tvalid_a;
        o_tlast    = sel_b ? tlast_b  : tlast_a;
        o_grant    = sel_b ? grant_b  : grant_a;
        o_busy     = sel_b ? busy_b   : busy_a;
        o_pkt      = sel_b ? pkt_b    : pkt_a;
    end

    function automatic logic [63:0] mk(input int p, input int b);
        return {8'(p), 24'h0, 32'(b)};
    endfunction

    // Packet sources: beat b of port p carries mk(p,b); packets are src_len beats long.
    int src_len[N];
    int src_left[N];
    int src_idx[N];
    int ld_len[N];
    int ld_pkts[N];
    logic ld_req = 1'b0;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            s_tvalid[p]          = (src_left[p] != 0);
            s_tlast[p]           = (src_idx[p] == src_len[p] - 1);
            s_tdata[p*W +: W]    = mk(p, src_idx[p]);
            s_tstrb[p*SW +: SW]  = 8'hF0 | 8'(p);
        end
    end

    always @(posedge clk) begin
        for (int p = 0; p < N; p++) begin
            if (ld_req) begin
                src_len[p]  <= ld_len[p];
                src_left[p] <= ld_pkts[p];
                src_idx[p]  <= 0;
            end else if (s_tvalid[p] && src_tready[p]) begin
                if (s_tlast[p]) begin
                    src_idx[p]  <= 0;
                    src_left[p] <= src_left[p] - 1;
                end else begin
                    src_idx[p] <= src_idx[p] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic load_src(input logic [3:0] en, input int len, input int pkts);
        for (int p = 0; p < N; p++) begin
            ld_len[p]  = len;
            ld_pkts[p] = en[p] ? pkts : 0;
        end
        ld_req = 1'b1;
        nxt();
        ld_req = 1'b0;
    endtask

    task automatic start_clean();
        rst = 1'b1;
        load_src(4'b0000, 1, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        mready;
        logic [3:0]  e_tready;
        logic        e_valid;
        logic        e_last;
        logic        e_busy;
        logic [1:0]  e_grant;
        logic [63:0] e_data;
    } vec_t;

    vec_t bp[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[$];
        int exp_ord[6];
        int viol;
        logic first;
        logic ev;

        // Backpressure table: port 1 sends 4 beats while m_tready alternates.
        bp[0] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 64'h0};
        bp[1] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, mk(1, 0)};
        bp[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, mk(1, 1)};
        bp[3] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, mk(1, 1)};
        bp[4] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, mk(1, 2)};
        bp[5] = '{1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, mk(1, 2)};
        bp[6] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, mk(1, 3)};
        bp[7] = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, mk(1, 3)};
        bp[8] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 64'h0};
        exp_ord = '{0, 1, 2, 3, 0, 1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", {o_tready, o_tvalid, o_tlast, o_busy, o_grant}, {4'b0000, 1'b0, 1'b0, 1'b0, 2'd3});
        chk("reset data", o_tdata, 64'h0);
        chk("reset strb", o_tstrb, 8'h00);
        chk("reset pkt", o_pkt, 32'd0);
        enable = 1'b1;

        // Single source: port 2, two 16-beat packets, gap 5
        start_clean();
        load_src(4'b0100, 16, 2);
        for (int k = 0; k < 40; k++) begin
            #1;
            ev = ((k >= 1) && (k <= 16)) || ((k >= 23) && (k <= 38));
            chk("t1 valid", o_tvalid, ev);
            if (ev) begin
                chk("t1 data", o_tdata, (k <= 16) ? mk(2, k - 1) : mk(2, k - 23));
                chk("t1 last", o_tlast, (k == 16) || (k == 38));
            end
            if (k == 1) begin
                chk("t1 grant", o_grant, 2'd2);
                chk("t1 strb", o_tstrb, 8'hF2);
            end
            if (k == 17) chk("t1 pkt1", {o_pkt, 3'(o_busy)}, {32'd1, 3'd0});
            if (k == 39) chk("t1 pkt2", o_pkt, 32'd2);
            nxt();
        end

        // All four ports requesting continuously, 4-beat packets
        start_clean();
        load_src(4'b1111, 4, 1000);
        viol = 0;
        first = 1'b1;
        for (int c = 0; c < 200 && o_pkt < 8; c++) begin
            #1;
            if ((o_tready & ~(4'b0001 << o_grant)) != 4'b0000) viol++;
            if (o_tvalid && m_tready) begin
                if (first) order.push_back(int'(o_tdata[63:56]));
                first = o_tlast;
            end
            nxt();
        end
        chk("t2 pkt count", o_pkt, 32'd8);
        chk("t2 order size", 64'(order.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            chk("t2 grant order", 64'(order[i]), 64'(exp_ord[i]));
        end
        chk("t2 stray tready", 64'(viol), 64'd0);

        // Backpressure table
        start_clean();
        load_src(4'b0010, 4, 1);
        for (int i = 0; i < 9; i++) begin
            m_tready = bp[i].mready;
            #1;
            chk("bp ctl", {o_tready, o_tvalid, o_tlast, o_busy, o_grant},
                {bp[i].e_tready, bp[i].e_valid, bp[i].e_last, bp[i].e_busy, bp[i].e_grant});
            chk("bp data", o_tdata, bp[i].e_data);
            nxt();
        end
        m_tready = 1'b1;

        // Enable drops during port 0 packet; port 3 waits until enable returns
        start_clean();
        load_src(4'b1001, 8, 1);
        for (int k = 0; k <= 22; k++) begin
            if (k == 3) enable = 1'b0;
            if (k == 21) enable = 1'b1;
            #1;
            if (k >= 1 && k <= 8) begin
                chk("t3 beat", {o_tvalid, o_tdata}, {1'b1, mk(0, k - 1)});
                chk("t3 last", o_tlast, (k == 8));
            end
            if (k == 20) chk("t3 held idle", {o_busy, o_tvalid, o_tready, o_grant}, {1'b0, 1'b0, 4'b0000, 2'd0});
            if (k == 22) chk("t3 regrant", {o_busy, o_grant, o_tdata}, {1'b1, 2'd3, mk(3, 0)});
            nxt();
        end
        repeat (15) nxt();

        // Asynchronous reset at beat 5 of a port 0 packet
        load_src(4'b0001, 8, 1);
        repeat (5) nxt();
        #1;
        chk("t4 beat5", {o_tvalid, o_tdata}, {1'b1, mk(0, 4)});
        chk("t4 pkt before", o_pkt, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t4 async ctl", {o_tready, o_tvalid, o_tlast, o_busy, o_grant}, {4'b0000, 1'b0, 1'b0, 1'b0, 2'd3});
        chk("t4 async data", {o_tdata, o_tstrb}, 72'h0);
        chk("t4 async pkt", o_pkt, 32'd0);
        nxt();
        load_src(4'b0101, 4, 1);
        rst = 1'b0;
        #1;
        chk("t4 idle after rst", {o_busy, o_tvalid, o_grant}, {1'b0, 1'b0, 2'd3});
        nxt();
        #1;
        chk("t4 first grant", {o_busy, o_grant, o_tdata}, {1'b1, 2'd0, mk(0, 0)});

        // Zero gap: ports 0 and 1, 3-beat packets, one idle cycle between them
        sel_b = 1'b1;
        start_clean();
        load_src(4'b0011, 3, 1);
        for (int k = 0; k <= 7; k++) begin
            #1;
            ev = (k >= 1 && k <= 3) || (k >= 5);
            chk("t5 valid", o_tvalid, ev);
            if (ev) chk("t5 data", o_tdata, (k <= 3) ? mk(0, k - 1) : mk(1, k - 5));
            if (k == 3) chk("t5 last", o_tlast, 1'b1);
            if (k == 4) chk("t5 idle", {o_busy, o_pkt}, {1'b0, 32'd1});
            nxt();
        end
        sel_b = 1'b0;

        // Packet counter wrap
        start_clean();
        force dut_a.r_pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut_a.r_pkt_count;
        load_src(4'b0010, 1, 1);
        #1;
        chk("t6 preload", o_pkt, 32'hFFFF_FFFF);
        nxt();
        #1;
        chk("t6 beat", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, mk(1, 0)});
        nxt();
        #1;
        chk("t6 wrap", {o_pkt, 3'(o_busy)}, {32'd0, 3'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
